// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the 2x2 convolution window feeder.
// FEEDER_STRIDE2_EN selects a window step of 2 in both axes (default step 1).
package conv_window_feeder_pkg;

  localparam int PIX_W        = 4;
  localparam int CONV_LATENCY = 4;
  localparam int FLUSH_CYCLES = 3;

`ifdef FEEDER_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Origin of the last 2x2 window along an axis of the given length.
  function automatic int last_origin(input int dim);
    return ((dim - 2) / STRIDE) * STRIDE;
  endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Load-stream and convolution-pipeline signals of the window feeder.
// master = host/pipeline side, slave = the feeder itself.
interface conv_window_feeder_if;
  import conv_window_feeder_pkg::*;

  logic             start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             busy;
  logic             in_valid;
  logic             ofm_valid;
  logic             done;
  logic [PIX_W-1:0] In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4;
  logic [PIX_W-1:0] In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4;

  modport master (
    output start, pix_valid, pix_data,
    input  busy, in_valid, ofm_valid, done,
    input  In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
    input  In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4
  );

  modport slave (
    input  start, pix_valid, pix_data,
    output busy, in_valid, ofm_valid, done,
    output In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
    output In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4
  );

endinterface

// File: rtl/conv_img_buffer.sv
// Weight + image store: one write port fed by the load stream, four combinational
// window read ports addressed by window origin, plus the four stored weights.
module conv_img_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  localparam int TOTAL = 4 + IMG_W * IMG_H,
  localparam int AW    = $clog2(TOTAL),
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [PIX_W-1:0]      wr_data_i,
  input  logic [RW-1:0]         row_i,
  input  logic [CW-1:0]         col_i,
  output logic [3:0][PIX_W-1:0] win_o,
  output logic [3:0][PIX_W-1:0] weight_o
);

  logic [PIX_W-1:0] mem_q [TOTAL];
  logic [AW-1:0]    base;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Weights occupy slots 0..3; pixel (r,c) lives at 4 + r*IMG_W + c.
  assign base = AW'(4 + int'(row_i) * IMG_W + int'(col_i));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      localparam int OFS = (gi / 2) * IMG_W + (gi % 2);
      logic [AW-1:0] addr;
      assign addr = base + AW'(OFS);
      // Forward the nibble being written so a 2x2 image can start feeding at once.
      assign win_o[gi]    = (wr_en_i && (wr_addr_i == addr)) ? wr_data_i : mem_q[addr];
      assign weight_o[gi] = mem_q[gi];
    end
  endgenerate

endmodule

// File: rtl/conv_window_feeder.sv
// Loads 4 weights and an IMG_W x IMG_H image, then streams 2x2 windows and flush cycles
// into a 4-stage convolution pipeline. Define FEEDER_STRIDE2_EN for stride-2 windows.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_window_feeder_if.slave bus
);

  localparam int TOTAL    = 4 + IMG_W * IMG_H;
  localparam int AW       = $clog2(TOTAL);
  localparam int RW       = $clog2(IMG_H);
  localparam int CW       = $clog2(IMG_W);
  localparam int FW       = $clog2(FLUSH_CYCLES);
  localparam int ROW_LAST = last_origin(IMG_H);
  localparam int COL_LAST = last_origin(IMG_W);

  state_e                  state_q, state_d;
  logic [AW-1:0]           load_cnt_q, load_cnt_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic [CONV_LATENCY-1:0] tag_q;
  logic                    busy_q, busy_d;
  logic                    in_valid_q, in_valid_d;
  logic                    done_q, done_d;
  logic [3:0][PIX_W-1:0]   ifm_q, ifm_d;
  logic [3:0][PIX_W-1:0]   weight_q, weight_d;
  logic [3:0][PIX_W-1:0]   win_pix, weights;
  logic                    wr_en;

  assign wr_en = (state_q == ST_LOAD) && bus.pix_valid;

  // Read ports follow the next window so the registered outputs line up with the state.
  conv_img_buffer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (load_cnt_q),
    .wr_data_i (bus.pix_data),
    .row_i     (row_d),
    .col_i     (col_d),
    .win_o     (win_pix),
    .weight_o  (weights)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      flush_cnt_q <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ifm_q       <= '0;
      weight_q    <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      flush_cnt_q <= flush_cnt_d;
      tag_q       <= {tag_q[CONV_LATENCY-2:0], state_q == ST_FEED};
      busy_q      <= busy_d;
      in_valid_q  <= in_valid_d;
      done_q      <= done_d;
      ifm_q       <= ifm_d;
      weight_q    <= weight_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.pix_valid) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == AW'(TOTAL - 1)) begin
            state_d = ST_FEED;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      ST_FEED: begin
        if (col_q == CW'(COL_LAST)) begin
          col_d = '0;
          if (row_q == RW'(ROW_LAST)) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end else begin
            row_d = row_q + RW'(STRIDE);
          end
        end else begin
          col_d = col_q + CW'(STRIDE);
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    in_valid_d = (state_d == ST_FEED) || (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE);
    ifm_d      = '0;
    weight_d   = '0;
    if (state_d == ST_FEED) begin
      ifm_d = win_pix;
    end
    if (in_valid_d) begin
      weight_d = weights;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.in_valid    = in_valid_q;
  assign bus.ofm_valid   = tag_q[CONV_LATENCY-1];
  assign bus.done        = done_q;
  assign bus.In_IFM_1    = ifm_q[0];
  assign bus.In_IFM_2    = ifm_q[1];
  assign bus.In_IFM_3    = ifm_q[2];
  assign bus.In_IFM_4    = ifm_q[3];
  assign bus.In_Weight_1 = weight_q[0];
  assign bus.In_Weight_2 = weight_q[1];
  assign bus.In_Weight_3 = weight_q[2];
  assign bus.In_Weight_4 = weight_q[3];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: loads weight/image sets, models the 4-cycle
// downstream MAC, and checks window results, flush/done timing, abort and start-ignore.
module tb_conv_window_feeder;
  import conv_window_feeder_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
`ifdef FEEDER_STRIDE2_EN
  localparam int N_WIN = ((W - 2) / 2 + 1) * ((H - 2) / 2 + 1);
`else
  localparam int N_WIN = (W - 1) * (H - 1);
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_feeder_if bus_if ();

  conv_window_feeder #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ifm_word();
    return int'({bus_if.In_IFM_4, bus_if.In_IFM_3, bus_if.In_IFM_2, bus_if.In_IFM_1});
  endfunction

  function automatic int wgt_word();
    return int'({bus_if.In_Weight_4, bus_if.In_Weight_3, bus_if.In_Weight_2, bus_if.In_Weight_1});
  endfunction

  function automatic int ctl_word();
    return int'({bus_if.busy, bus_if.in_valid, bus_if.ofm_valid, bus_if.done});
  endfunction

  task automatic run_job(input string name, input logic [3:0] w[4], input logic [3:0] px[16],
                         input bit gappy, input bit poke_start, input int abort_at,
                         input int exp_n, input int exp_sum[9]);
    int  idx = 0;
    bit  ph = 1'b0;
    int  hist[5];
    int  n_ofm = 0;
    int  n_done = 0;
    int  done_cyc = -1;
    int  sum;
    int  exp_w;
    exp_w = int'({w[3], w[2], w[1], w[0]});
    foreach (hist[j]) hist[j] = 0;

    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_load_busy", name), int'(bus_if.busy), 1);
    chk($sformatf("%s_load_inval", name), int'(bus_if.in_valid), 0);

    while (idx < 20) begin
      if (gappy && ph) begin
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = 4'hF;
      end else begin
        bus_if.pix_valid = 1'b1;
        bus_if.pix_data  = (idx < 4) ? w[idx] : px[idx-4];
        idx++;
      end
      ph = !ph;
      @(posedge clk); #1;
    end
    bus_if.pix_valid = 1'b0;

    for (int cyc = 0; cyc < N_WIN + 9; cyc++) begin
      if (cyc == abort_at) begin
        @(posedge clk); #1 rst_n = 1'b0;
      end
      @(negedge clk);
      sum = 0;
      if (bus_if.in_valid) begin
        sum = int'(bus_if.In_IFM_1) * int'(bus_if.In_Weight_1)
            + int'(bus_if.In_IFM_2) * int'(bus_if.In_Weight_2)
            + int'(bus_if.In_IFM_3) * int'(bus_if.In_Weight_3)
            + int'(bus_if.In_IFM_4) * int'(bus_if.In_Weight_4);
      end
      for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = sum;
      if (bus_if.ofm_valid) begin
        if (n_ofm < exp_n) chk($sformatf("%s_ofm%0d", name, n_ofm), hist[4], exp_sum[n_ofm]);
        n_ofm++;
      end
      if (bus_if.done) begin
        n_done++;
        done_cyc = cyc;
        chk($sformatf("%s_done_with_ofm", name), int'(bus_if.ofm_valid), 1);
      end
      if (cyc == 0) begin
        chk($sformatf("%s_feed_start", name), int'(bus_if.in_valid), 1);
        chk($sformatf("%s_weights", name), wgt_word(), exp_w);
      end
      if (abort_at < 0 && cyc == N_WIN) begin
        chk($sformatf("%s_flush_valid", name), int'(bus_if.in_valid), 1);
        chk($sformatf("%s_flush_ifm", name), ifm_word(), 0);
        chk($sformatf("%s_flush_weights", name), wgt_word(), exp_w);
      end
      if (abort_at < 0 && cyc == N_WIN + 3) begin
        chk($sformatf("%s_done_inval", name), int'(bus_if.in_valid), 0);
      end
      if (cyc == abort_at) begin
        chk($sformatf("%s_abort_ctl", name), ctl_word(), 0);
        chk($sformatf("%s_abort_ifm", name), ifm_word(), 0);
        chk($sformatf("%s_abort_wgt", name), wgt_word(), 0);
      end
      if (abort_at >= 0 && cyc == abort_at + 2) rst_n = 1'b1;
      if (poke_start && cyc == 2) bus_if.start = 1'b1;
      if (poke_start && cyc == 3) bus_if.start = 1'b0;
    end

    chk($sformatf("%s_ofm_count", name), n_ofm, exp_n);
    chk($sformatf("%s_done_count", name), n_done, (abort_at < 0) ? 1 : 0);
    if (abort_at < 0) chk($sformatf("%s_done_cycle", name), done_cyc, N_WIN + 3);
    chk($sformatf("%s_idle_busy", name), int'(bus_if.busy), 0);
    $display("job %-6s ofm_pulses=%0d done_pulses=%0d done_cycle=%0d", name, n_ofm, n_done, done_cyc);
  endtask

  initial begin
    logic [3:0] w_one[4];
    logic [3:0] w_all[4];
    logic [3:0] w_mix[4];
    logic [3:0] px_ramp[16];
    logic [3:0] px_all[16];
    int         e_ramp[9];
    int         e_900[9];
    int         e_mix[9];

    bus_if.start     = 1'b0;
    bus_if.pix_valid = 1'b0;
    bus_if.pix_data  = 4'h0;
    rst_n            = 1'b0;

    for (int i = 0; i < 16; i++) begin
      px_ramp[i] = 4'(i);
      px_all[i]  = 4'hF;
    end
    w_one = '{4'd1, 4'd1, 4'd1, 4'd1};
    w_all = '{4'd15, 4'd15, 4'd15, 4'd15};
    w_mix = '{4'd2, 4'd0, 4'd0, 4'd1};
    e_900 = '{default: 900};
`ifdef FEEDER_STRIDE2_EN
    e_ramp = '{10, 18, 42, 50, 0, 0, 0, 0, 0};
    e_mix  = '{5, 11, 29, 35, 0, 0, 0, 0, 0};
`else
    e_ramp = '{10, 14, 18, 26, 30, 34, 42, 46, 50};
    e_mix  = '{5, 8, 11, 17, 20, 23, 29, 32, 35};
`endif

    @(negedge clk);
    chk("reset_ctl", ctl_word(), 0);
    chk("reset_ifm", ifm_word(), 0);
    chk("reset_wgt", wgt_word(), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_job("ramp",  w_one, px_ramp, 1'b0, 1'b0, -1, N_WIN, e_ramp);
    run_job("gappy", w_one, px_ramp, 1'b1, 1'b0, -1, N_WIN, e_ramp);
    run_job("sat",   w_all, px_all,  1'b0, 1'b1, -1, N_WIN, e_900);
    run_job("abort", w_one, px_ramp, 1'b0, 1'b0,  2, 0,     e_ramp);
    run_job("fresh", w_mix, px_ramp, 1'b0, 1'b0, -1, N_WIN, e_mix);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 4, image width in pixels (>=2).
REQ-002 SHALL have parameter IMG_H, default 4, image height in pixels (>=2).
REQ-003 SHALL have ports:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  start  in  1  one-cycle request to begin a load/feed job.
  pix_valid  in  1  load-stream qualifier.
  pix_data  in  4  load-stream nibble: 4 weights, then IMG_W*IMG_H pixels in raster order.
  busy  out  1  high in every state except IDLE.
  in_valid  out  1  convolution-pipeline advance strobe.
  In_IFM_1..In_IFM_4  out  4 each  window top-left, top-right, bottom-left, bottom-right.
  In_Weight_1..In_Weight_4  out  4 each  stored weights 1..4.
  ofm_valid  out  1  high when downstream Out_OFM holds a window result.
  done  out  1  one-cycle end-of-job pulse.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, FEED, FLUSH, DONE; all outputs registered.
REQ-005 IDLE->LOAD on start=1; start SHALL be ignored in any other state.
REQ-006 LOAD SHALL accept one nibble per cycle with pix_valid=1, hold count on gaps, and ignore pix_valid outside LOAD.
REQ-007 After the (4+IMG_W*IMG_H)th accepted nibble, LOAD->FEED next cycle.
REQ-008 FEED SHALL drive in_valid=1 and one 2x2 window per cycle, raster order, stride 1: N=(IMG_W-1)*(IMG_H-1) windows, no gaps.
REQ-009 Weights SHALL be driven unchanged on In_Weight_1..4 in FEED and FLUSH.
REQ-010 FEED->FLUSH after window N-1; FLUSH SHALL last exactly 3 cycles with in_valid=1 and In_IFM_* = 0.
REQ-011 FLUSH->DONE; DONE SHALL last one cycle with done=1, in_valid=0, then return to IDLE.
REQ-012 If window k is driven in cycle F+k (F = first FEED cycle), ofm_valid SHALL be 1 in cycle F+k+4, via a 4-stage tag shift register advanced every cycle.
REQ-013 ofm_valid SHALL pulse exactly N times per job; the last pulse SHALL coincide with done.
REQ-014 in_valid and In_IFM_* SHALL be 0 in IDLE, LOAD and DONE.
REQ-015 Window row/column counters SHALL wrap column at IMG_W-2 (stride 1) and terminate at row IMG_H-2.

Reset
REQ-016 rst_n=0 SHALL force IDLE immediately; busy, in_valid, ofm_valid, done, In_IFM_*, In_Weight_* = 0; counters and tag register cleared.
REQ-017 Reset mid-job SHALL abandon the job: no further ofm_valid or done; the next start begins a fresh load.
REQ-018 Image/weight storage need not be cleared by reset.

Configuration
REQ-019 With FEEDER_STRIDE2_EN defined, windows SHALL step by 2 in both axes: N=floor((IMG_W-2)/2+1)*floor((IMG_H-2)/2+1).
REQ-020 Without FEEDER_STRIDE2_EN, stride SHALL be 1 per REQ-008; FSM, flush and ofm_valid timing are identical in both builds.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding, PIX_W=4, CONV_LATENCY=4 and FLUSH_CYCLES=3.
REQ-022 The image/weight store SHALL be a sub-module conv_img_buffer: write port for LOAD, four combinational read ports addressed by window origin.

Verification
REQ-023 Weights 1,1,1,1; pixels 0..15; 4x4 -> OFM sequence 10,14,18,26,30,34,42,46,50 with 9 ofm_valid pulses; done on the 9th.
REQ-024 All weights and pixels 15 -> nine results of 900, no overflow in the 12-bit downstream output.
REQ-025 FEEDER_STRIDE2_EN, same data as REQ-023 -> 10,18,42,50; 4 ofm_valid pulses.
REQ-026 pix_valid toggling 1/0 during LOAD -> identical results to REQ-023; FEED starts one cycle after the 20th accepted nibble.
REQ-027 rst_n asserted on the 3rd FEED cycle -> all outputs 0 next sample; no done; a new start with fresh data completes normally.
REQ-028 start pulsed during FEED -> ignored; exactly one done per job.
